bullet_hit_scanner: RTL and testbench
=====================================

# bullet_hit_scanner

Sequential collision engine for the game core. It checks up to NUM_BULLETS bullet boxes against NUM_TARGETS alien/shield boxes, one bullet/target pair per clock, once per frame. It returns sticky per-bullet and per-target hit masks plus a hit count. It sits between the sprite-position registers and the game-state update logic, triggered once per frame by the VGA frame tick.

## Interface
- COORD_W, 11, width of one screen coordinate.
- NUM_BULLETS, 4, number of bullet slots scanned.
- NUM_TARGETS, 16, number of target slots scanned.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  frame tick; a one-cycle pulse that requests a scan.
- bullet_box  in  NUM_BULLETS*4*COORD_W  packed boxes. Slot i occupies [(i+1)*4*COORD_W-1 : i*4*COORD_W] as {bottomy, topy, rightx, leftx}, each COORD_W bits.
- bullet_valid  in  NUM_BULLETS  slot i holds a live bullet.
- target_box  in  NUM_TARGETS*4*COORD_W  same packing as bullet_box.
- target_alive  in  NUM_TARGETS  slot j holds a live target.
- busy  out  1  a scan is in progress.
- done  out  1  one-cycle pulse; results are valid.
- bullet_hit  out  NUM_BULLETS  bullet i struck a target in the last scan.
- target_hit  out  NUM_TARGETS  target j was struck in the last scan.
- hit_count  out  clog2(min(NB,NT)+1)  number of hits in the last scan.

## Operation
- The state machine has three states.
  - IDLE to SCAN when start=1. At that edge the block snapshots bullet_box, bullet_valid, target_box and target_alive into internal registers, clears bullet_hit, target_hit and hit_count, and sets b_idx=0, t_idx=0.
  - SCAN to DONE on the edge that evaluates the last pair (b_idx=NB-1, t_idx=NT-1).
  - DONE to IDLE unconditionally after one cycle.
- Pair order: t_idx is the inner loop and b_idx the outer loop. t_idx wraps from NT-1 to 0 and b_idx increments at the same time.
- A pair is eligible when bullet b is valid and not yet hit, and target t is alive and not yet hit. Both conditions use the snapshot plus the current masks.
- Overlap test uses inclusive bounds with y increasing downward. It is true when all of the following hold: b.topy <= t.bottomy, b.bottomy >= t.topy, b.leftx <= t.rightx, b.rightx >= t.leftx.
- All comparisons are unsigned and COORD_W wide.
- Edge-touching boxes count as a hit. A zero-area box (top==bottom, left==right) is legal.
- When an eligible pair overlaps, the block sets bullet_hit[b] and target_hit[t] and increments hit_count.
- One bullet kills at most one target: the lowest-index overlapping target wins. One target absorbs at most one bullet: the lowest-index bullet wins.
- Ineligible pairs still consume their cycle, so latency is fixed.
- A start pulse in SCAN or DONE is ignored. Input changes during a scan are ignored because the block works from the snapshot.
- Results hold from DONE until the next accepted start.

## Timing
- Reset values: busy=0, done=0, bullet_hit=0, target_hit=0, hit_count=0, state IDLE, indices 0.
- If rst asserts mid-scan, the block returns to IDLE immediately and all results clear. No done pulse is produced.
- busy=1 for exactly NB*NT cycles, beginning the cycle after the start edge.
- done=1 for exactly one cycle, which is the cycle after busy falls.
- Start-to-done latency is NB*NT+1 edges: 65 at the defaults.
- bullet_hit, target_hit and hit_count are stable and final whenever done=1 and throughout the following IDLE.
- Minimum start spacing is NB*NT+2 cycles. Frame ticks are far sparser than this.

## Structure
- The shared package invaders_pkg holds:
  - COORD_W;
  - box field offsets (LEFT=0, RIGHT=1, TOP=2, BOTTOM=3);
  - the box width constant BOX_W=4*COORD_W;
  - the state encodings for IDLE/SCAN/DONE.
- Sub-module box_overlap: a purely combinational test of two packed boxes, producing a one-bit overlap. It is instantiated once and reused by the other sprite checks.
- All sequential logic (state register, indices, snapshot registers, masks, count) lives in bullet_hit_scanner.

## Test plan
- Single hit, defaults. Bullet 0 = {bottom=105, top=100, right=52, left=50}, valid; target 3 = {120, 104, 60, 40}, alive; everything else invalid or dead. Required: done at edge 65, bullet_hit=4'b0001, target_hit bit 3 only, hit_count=1.
- Edge touch and miss. A bullet whose topy equals the target bottomy gives a hit. Moving the bullet down 1 pixel gives no hit, with done still at edge 65.
- Priority. One bullet overlaps targets 2 and 5: only target 2 is hit. Two bullets overlap target 7: only bullet 0 is hit, and bullet 1 stays free.
- Masking. An overlapping pair with bullet_valid=0 or target_alive=0 leaves all masks zero and hit_count=0.
- Re-start and stale inputs. A start pulsed at cycle 10 of a scan is ignored. Changing target_box mid-scan does not change the result. busy is high for exactly 64 cycles.
- Reset mid-scan. rst asserted at scan cycle 30 gives busy=0 and masks cleared in the same cycle, and no done pulse. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared constants for the sprite collision logic: coordinate width, box field
// layout and scanner state encodings.
package invaders_pkg;

  localparam int COORD_W = 11;

  // Field slot inside a packed box: {bottomy, topy, rightx, leftx}
  localparam int LEFT   = 0;
  localparam int RIGHT  = 1;
  localparam int TOP    = 2;
  localparam int BOTTOM = 3;

  localparam int BOX_W = 4 * COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational inclusive-bounds overlap test of two packed boxes (y grows downward).
module box_overlap
  import invaders_pkg::*;
#(
  parameter int CW = invaders_pkg::COORD_W
) (
  input  logic [4*CW-1:0] a,
  input  logic [4*CW-1:0] b,
  output logic            hit
);

  logic [CW-1:0] a_left, a_right, a_top, a_bottom;
  logic [CW-1:0] b_left, b_right, b_top, b_bottom;

  assign a_left   = a[LEFT*CW   +: CW];
  assign a_right  = a[RIGHT*CW  +: CW];
  assign a_top    = a[TOP*CW    +: CW];
  assign a_bottom = a[BOTTOM*CW +: CW];
  assign b_left   = b[LEFT*CW   +: CW];
  assign b_right  = b[RIGHT*CW  +: CW];
  assign b_top    = b[TOP*CW    +: CW];
  assign b_bottom = b[BOTTOM*CW +: CW];

  // Touching edges count as overlap, so zero-area boxes can still hit
  assign hit = (a_top <= b_bottom) && (a_bottom >= b_top) &&
               (a_left <= b_right) && (a_right >= b_left);

endmodule

// File: rtl/bullet_hit_scanner.sv
// Once-per-frame bullet/target collision scan, one pair per clock, producing
// sticky hit masks and a hit count from a snapshot taken at the frame tick.
module bullet_hit_scanner
  import invaders_pkg::*;
#(
  parameter int COORD_W     = invaders_pkg::COORD_W,
  parameter int NUM_BULLETS = 4,
  parameter int NUM_TARGETS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_BULLETS*4*COORD_W-1:0]   bullet_box,
  input  logic [NUM_BULLETS-1:0]             bullet_valid,
  input  logic [NUM_TARGETS*4*COORD_W-1:0]   target_box,
  input  logic [NUM_TARGETS-1:0]             target_alive,
  output logic                               busy,
  output logic                               done,
  output logic [NUM_BULLETS-1:0]             bullet_hit,
  output logic [NUM_TARGETS-1:0]             target_hit,
  output logic [$clog2(((NUM_BULLETS < NUM_TARGETS) ? NUM_BULLETS : NUM_TARGETS) + 1)-1:0] hit_count
);

  localparam int BW     = 4 * COORD_W;
  localparam int BI_W   = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int TI_W   = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int MIN_BT = (NUM_BULLETS < NUM_TARGETS) ? NUM_BULLETS : NUM_TARGETS;
  localparam int HC_W   = $clog2(MIN_BT + 1);

  localparam logic [BI_W-1:0] B_LAST = BI_W'(NUM_BULLETS - 1);
  localparam logic [TI_W-1:0] T_LAST = TI_W'(NUM_TARGETS - 1);

  scan_state_t state_q, state_d;

  logic [BW-1:0]          bbox_q [NUM_BULLETS];
  logic [BW-1:0]          tbox_q [NUM_TARGETS];
  logic [NUM_BULLETS-1:0] bvalid_q;
  logic [NUM_TARGETS-1:0] talive_q;
  logic [BI_W-1:0]        b_idx;
  logic [TI_W-1:0]        t_idx;

  logic accept, last_pair, eligible, overlap;

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_pair = (b_idx == B_LAST) && (t_idx == T_LAST);
  // Current masks gate eligibility, giving lowest-index priority on both sides
  assign eligible  = bvalid_q[b_idx] && !bullet_hit[b_idx] &&
                     talive_q[t_idx] && !target_hit[t_idx];

  box_overlap #(.CW(COORD_W)) u_overlap (
    .a   (bbox_q[b_idx]),
    .b   (tbox_q[t_idx]),
    .hit (overlap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (last_pair) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BULLETS; i++) bbox_q[i] <= '0;
      for (int j = 0; j < NUM_TARGETS; j++) tbox_q[j] <= '0;
      bvalid_q   <= '0;
      talive_q   <= '0;
      bullet_hit <= '0;
      target_hit <= '0;
      hit_count  <= '0;
      b_idx      <= '0;
      t_idx      <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_BULLETS; i++) bbox_q[i] <= bullet_box[i*BW +: BW];
      for (int j = 0; j < NUM_TARGETS; j++) tbox_q[j] <= target_box[j*BW +: BW];
      bvalid_q   <= bullet_valid;
      talive_q   <= target_alive;
      bullet_hit <= '0;
      target_hit <= '0;
      hit_count  <= '0;
      b_idx      <= '0;
      t_idx      <= '0;
    end else if (state_q == ST_SCAN) begin
      if (eligible && overlap) begin
        bullet_hit[b_idx] <= 1'b1;
        target_hit[t_idx] <= 1'b1;
        hit_count         <= hit_count + HC_W'(1);
      end
      if (t_idx == T_LAST) begin
        t_idx <= '0;
        b_idx <= last_pair ? '0 : b_idx + BI_W'(1);
      end else begin
        t_idx <= t_idx + TI_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Directed self-checking bench for bullet_hit_scanner with hand-computed expectations.
module tb_bullet_hit_scanner;
  import invaders_pkg::*;

  localparam int NB = 4;
  localparam int NT = 16;
  localparam int CW = 11;
  localparam int BW = 4 * CW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NB*BW-1:0]  bullet_box;
  logic [NB-1:0]     bullet_valid;
  logic [NT*BW-1:0]  target_box;
  logic [NT-1:0]     target_alive;
  logic              busy;
  logic              done;
  logic [NB-1:0]     bullet_hit;
  logic [NT-1:0]     target_hit;
  logic [2:0]        hit_count;

  int n_cmp = 0;
  int n_err = 0;

  bullet_hit_scanner #(.COORD_W(CW), .NUM_BULLETS(NB), .NUM_TARGETS(NT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bullet_box   (bullet_box),
    .bullet_valid (bullet_valid),
    .target_box   (target_box),
    .target_alive (target_alive),
    .busy         (busy),
    .done         (done),
    .bullet_hit   (bullet_hit),
    .target_hit   (target_hit),
    .hit_count    (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_box(input int bottom, input int top,
                                          input int right, input int left);
    return {CW'(bottom), CW'(top), CW'(right), CW'(left)};
  endfunction

  task automatic clear_inputs();
    bullet_box   = '0;
    bullet_valid = '0;
    target_box   = '0;
    target_alive = '0;
  endtask

  task automatic set_bullet(input int i, input logic [BW-1:0] bx);
    bullet_box[i*BW +: BW] = bx;
    bullet_valid[i]        = 1'b1;
  endtask

  task automatic set_target(input int j, input logic [BW-1:0] bx);
    target_box[j*BW +: BW] = bx;
    target_alive[j]        = 1'b1;
  endtask

  // mode 1: re-pulse start and disturb the inputs partway through the scan
  task automatic run_scan(input int mode, output int edges, output int bc);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 1;
    bc    = 0;
    if (busy) bc++;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (mode == 1 && edges == 10) begin
        start = 1'b1;
        set_target(3, mk_box(500, 490, 500, 490));
        set_bullet(1, mk_box(105, 100, 52, 50));
        set_target(5, mk_box(120, 104, 60, 40));
      end
      if (mode == 1 && edges == 11) start = 1'b0;
      if (done) break;
      if (busy) bc++;
    end
  endtask

  task automatic expect_scan(input string tag, input int mode, input logic [NB-1:0] eb,
                             input logic [NT-1:0] et, input int ec);
    int edges, bc;
    run_scan(mode, edges, bc);
    check({tag, "_latency"}, edges, 65);
    check({tag, "_busy_cycles"}, bc, 64);
    check({tag, "_bullet_hit"}, bullet_hit, eb);
    check({tag, "_target_hit"}, target_hit, et);
    check({tag, "_hit_count"}, hit_count, ec);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_count"}, hit_count, ec);
    check({tag, "_hold_target"}, target_hit, et);
  endtask

  initial begin
    int done_seen;
    rst   = 1'b1;
    start = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bullet_hit", bullet_hit, 0);
    check("rst_target_hit", target_hit, 0);
    check("rst_hit_count", hit_count, 0);
    @(negedge clk) rst = 1'b0;

    // single hit
    clear_inputs();
    set_bullet(0, mk_box(105, 100, 52, 50));
    set_target(3, mk_box(120, 104, 60, 40));
    expect_scan("single", 0, 4'b0001, 16'h0008, 1);

    // vertical edge touch, then one pixel lower misses
    clear_inputs();
    set_bullet(0, mk_box(125, 120, 52, 50));
    set_target(3, mk_box(120, 104, 60, 40));
    expect_scan("touch_y", 0, 4'b0001, 16'h0008, 1);
    set_bullet(0, mk_box(126, 121, 52, 50));
    expect_scan("miss_y", 0, 4'b0000, 16'h0000, 0);

    // horizontal edge touch
    clear_inputs();
    set_bullet(0, mk_box(110, 106, 40, 35));
    set_target(3, mk_box(120, 104, 60, 40));
    expect_scan("touch_x", 0, 4'b0001, 16'h0008, 1);

    // one bullet over two targets: lowest target wins
    clear_inputs();
    set_bullet(0, mk_box(105, 100, 52, 50));
    set_target(2, mk_box(120, 104, 60, 40));
    set_target(5, mk_box(120, 104, 60, 40));
    expect_scan("prio_tgt", 0, 4'b0001, 16'h0004, 1);

    // two bullets over one target: lowest bullet wins
    clear_inputs();
    set_bullet(0, mk_box(105, 100, 52, 50));
    set_bullet(1, mk_box(105, 100, 52, 50));
    set_target(7, mk_box(120, 104, 60, 40));
    expect_scan("prio_blt", 0, 4'b0001, 16'h0080, 1);

    // two independent hits
    clear_inputs();
    set_bullet(0, mk_box(105, 100, 52, 50));
    set_target(3, mk_box(120, 104, 60, 40));
    set_bullet(2, mk_box(305, 300, 202, 200));
    set_target(10, mk_box(310, 290, 210, 195));
    expect_scan("multi", 0, 4'b0101, 16'h0408, 2);

    // masking by valid / alive
    clear_inputs();
    set_bullet(0, mk_box(105, 100, 52, 50));
    set_target(3, mk_box(120, 104, 60, 40));
    bullet_valid = '0;
    expect_scan("mask_valid", 0, 4'b0000, 16'h0000, 0);
    bullet_valid = 4'b0001;
    target_alive = '0;
    expect_scan("mask_alive", 0, 4'b0000, 16'h0000, 0);

    // re-start ignored, mid-scan input changes ignored
    clear_inputs();
    set_bullet(0, mk_box(105, 100, 52, 50));
    set_target(3, mk_box(120, 104, 60, 40));
    expect_scan("stale", 1, 4'b0001, 16'h0008, 1);

    // reset mid-scan
    clear_inputs();
    set_bullet(0, mk_box(105, 100, 52, 50));
    set_target(3, mk_box(120, 104, 60, 40));
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("rstmid_pre_hit", bullet_hit, 4'b0001);
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_bullet_hit", bullet_hit, 0);
    check("rstmid_target_hit", target_hit, 0);
    check("rstmid_hit_count", hit_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("rstmid_no_done", done_seen, 0);
    expect_scan("after_rst", 0, 4'b0001, 16'h0008, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
